// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 3-digit multiplexed seven-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens digits.
module count_bcd_display #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  number,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int unsigned     RW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]   REFRESH_MAX = RW'(REFRESH_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? 3'h7 : 3'h0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    logic [1:0]    state_q, state_d;
    logic [19:0]   shreg_q, shreg_d;
    logic [2:0]    iter_q, iter_d;
    logic [7:0]    conv_q, conv_d;
    logic [7:0]    last_conv_q, last_conv_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          bcd_valid_q, bcd_valid_d;
    logic [19:0]   adj;

    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [2:0]    an_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Converter: shift register holds {hundreds, tens, ones, binary}; eight add-3/shift steps.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        last_conv_d = last_conv_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        adj         = shreg_q;
        case (state_q)
            IDLE: begin
                if (number != last_conv_q) begin
                    shreg_d = {12'h000, number};
                    conv_d  = number;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (adj[8+4*i +: 4] >= 4'd5)
                        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
                end
                shreg_d = {adj[18:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d       = shreg_q[19:8];
                last_conv_d = conv_q;
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            iter_q      <= '0;
            conv_q      <= '0;
            last_conv_q <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            last_conv_q <= last_conv_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // Display scan: digit index advances each time the refresh counter wraps.
    always_comb begin
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            refresh_d = refresh_q + 1'b1;
            digit_d   = digit_q;
        end

        nib    = 4'd0;
        blank  = 1'b1;
        an_raw = 3'b000;
        case (digit_q)
            2'd0: begin
                nib    = bcd_q[3:0];
                blank  = 1'b0;
                an_raw = 3'b001;
            end
            2'd1: begin
                nib    = bcd_q[7:4];
                blank  = LZ_BLANK && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                an_raw = 3'b010;
            end
            2'd2: begin
                nib    = bcd_q[11:8];
                blank  = LZ_BLANK && (bcd_q[11:8] == 4'd0);
                an_raw = 3'b100;
            end
            default: begin
                nib    = 4'd0;
                blank  = 1'b1;
                an_raw = 3'b000;
            end
        endcase

        seg_raw = blank ? 7'h00 : seg_decode(nib);
        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d    = (SEG_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            digit_q   <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: vector table, scoreboard on bcd_valid, corner sequences.
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  number;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int passed = 0;
    logic [11:0] sb_q[$];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] BZ = 7'h00;
`else
    localparam logic [6:0] BZ = 7'h3F;
`endif

    typedef struct {
        logic [7:0]  num;
        logic [11:0] exp_bcd;
        logic [6:0]  seg_o;
        logic [6:0]  seg_t;
        logic [6:0]  seg_h;
    } vec_t;

    vec_t vecs[7];

    count_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .number    (number),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every bcd_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bcd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'(bcd_valid), 32'd0);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                chk("bcd_value", 32'(bcd), 32'(e));
            end
        end
    end

    task automatic wait_valid(input string name);
        int lat;
        lat = 99;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bcd_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk(name, 32'(lat), 32'd10);
    endtask

    task automatic check_digits(input vec_t v);
        for (int d = 0; d < 3; d++) begin
            logic [2:0] oh;
            logic [6:0] es;
            int n;
            oh = 3'b001 << d;
            es = (d == 0) ? v.seg_o : ((d == 1) ? v.seg_t : v.seg_h);
            n  = 0;
            while (an !== oh && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("digit_an", 32'(an), 32'(oh));
            chk("digit_seg", 32'(seg), 32'(es));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int first_v;
        int second_v;
        vecs[0] = '{8'd23,  12'h023, 7'h4F, 7'h5B, BZ};
        vecs[1] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B};
        vecs[2] = '{8'd7,   12'h007, 7'h07, BZ,    BZ};
        vecs[3] = '{8'd100, 12'h100, 7'h3F, 7'h3F, 7'h06};
        vecs[4] = '{8'd0,   12'h000, 7'h3F, BZ,    BZ};
        vecs[5] = '{8'd99,  12'h099, 7'h6F, 7'h6F, BZ};
        vecs[6] = '{8'd1,   12'h001, 7'h06, BZ,    BZ};

        rst    = 1'b0;
        number = 8'd0;
        #12;
        chk("reset_seg",   32'(seg),       32'h00);
        chk("reset_an",    32'(an),        32'h0);
        chk("reset_bcd",   32'(bcd),       32'h000);
        chk("reset_valid", 32'(bcd_valid), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] oh;
            oh = 3'b001 << ((k - 1) / 4);
            @(negedge clk);
            chk("scan_an", 32'(an), 32'(oh));
            chk("scan_seg", 32'(seg), 32'((oh == 3'b001) ? 7'h3F : BZ));
        end

        foreach (vecs[i]) begin
            number = vecs[i].num;
            sb_q.push_back(vecs[i].exp_bcd);
            wait_valid("latency");
            @(negedge clk);
            chk("valid_pulse_end", 32'(bcd_valid), 32'd0);
            check_digits(vecs[i]);
        end

        // Change mid-conversion: first result unaffected, second captured right after.
        @(negedge clk);
        number   = 8'd23;
        first_v  = 0;
        second_v = 0;
        sb_q.push_back(12'h023);
        sb_q.push_back(12'h100);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) number = 8'd100;
            if (bcd_valid === 1'b1) begin
                if (first_v == 0) first_v = k;
                else if (second_v == 0) second_v = k;
            end
        end
        chk("midchange_first_at",  32'(first_v),  32'd10);
        chk("midchange_second_at", 32'(second_v), 32'd20);
        check_digits(vecs[3]);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        number = 8'd50;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_bcd",   32'(bcd),       32'h000);
        chk("async_rst_valid", 32'(bcd_valid), 32'd0);
        chk("async_rst_seg",   32'(seg),       32'h00);
        chk("async_rst_an",    32'(an),        32'h0);
        number = 8'd23;
        @(negedge clk);
        rst = 1'b1;
        sb_q.push_back(12'h023);
        wait_valid("latency_after_reset");
        @(negedge clk);
        check_digits(vecs[0]);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
